pipe_ctrl: RTL and testbench

Pipeline control sequencer that consumes the stall/flush requests produced by the hazard detection unit and applies them to the five-stage MIPS pipeline. It generates per-stage register enables and valid bits, and arbitrates instruction-cache and data-cache busy stalls. It latches a branch/JR/jump redirect that arrives while fetch is blocked and replays it to the PC once fetch resumes. It also keeps saturating stall-cycle and redirect counters for performance analysis.

---
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl.sv | 79 +++++++
 tb/tb_pipe_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard unit / caches and the pipeline control sequencer.
// The master drives stall, flush and redirect requests; the slave returns enables, valid bits and counters.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             iStallDec;
   logic             iFlushIfDec;
   logic             iFlushDecEx;
   logic             iFlushExMem;
   logic             iICacheStall;
   logic             iDCacheStall;
   logic             iRedirectValid;
   logic [31:0]      iRedirectPC;
   logic             oPCEnable;
   logic             oPCRedirect;
   logic [31:0]      oRedirectPC;
   logic             oEnIfDec;
   logic             oEnDecEx;
   logic             oEnExMem;
   logic             oEnMemWb;
   logic             oValidDec;
   logic             oValidEx;
   logic             oValidMem;
   logic             oValidWb;
   logic [CNT_W-1:0] oStallCnt;
   logic [CNT_W-1:0] oRedirCnt;

   modport master (
      output iStallDec, iFlushIfDec, iFlushDecEx, iFlushExMem,
             iICacheStall, iDCacheStall, iRedirectValid, iRedirectPC,
      input  oPCEnable, oPCRedirect, oRedirectPC,
             oEnIfDec, oEnDecEx, oEnExMem, oEnMemWb,
             oValidDec, oValidEx, oValidMem, oValidWb,
             oStallCnt, oRedirCnt
   );

   modport slave (
      input  iStallDec, iFlushIfDec, iFlushDecEx, iFlushExMem,
             iICacheStall, iDCacheStall, iRedirectValid, iRedirectPC,
      output oPCEnable, oPCRedirect, oRedirectPC,
             oEnIfDec, oEnDecEx, oEnExMem, oEnMemWb,
             oValidDec, oValidEx, oValidMem, oValidWb,
             oStallCnt, oRedirCnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: register enables, stage valid bits, D/I-cache stall arbitration,
// deferred redirect replay across I-cache stalls, and saturating stall/redirect counters.
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   typedef enum logic {RUN, PEND} state_t;

   state_t           state, stateNxt;
   logic [31:0]      pendPc, pendPcNxt;
   logic             validDec, validEx, validMem, validWb;
   logic [CNT_W-1:0] stallCnt, redirCnt;
   logic             dfz, ifz, redir, pcEnable;

   assign dfz = bus.iDCacheStall;
   assign ifz = bus.iICacheStall;

   always_comb begin
      stateNxt  = state;
      pendPcNxt = pendPc;
      redir     = ~dfz & ~ifz & ((state == PEND) | bus.iRedirectValid);
      pcEnable  = ~rst & ~dfz & ~ifz & (~bus.iStallDec | redir);
      // Newest redirect seen while fetch is blocked is the one replayed.
      if (bus.iRedirectValid & ifz & ~dfz)
         pendPcNxt = bus.iRedirectPC;
      case (state)
         RUN:  if (bus.iRedirectValid & ifz & ~dfz) stateNxt = PEND;
         PEND: if (~ifz & ~dfz)                      stateNxt = RUN;
         default: stateNxt = RUN;
      endcase
   end

   assign bus.oPCEnable   = pcEnable;
   assign bus.oPCRedirect = ~rst & redir;
   assign bus.oRedirectPC = (state == PEND) ? pendPc : bus.iRedirectPC;
   // Enables stay high in reset so the downstream registers take their clear.
   assign bus.oEnIfDec    = rst | (~dfz & (~bus.iStallDec | bus.iFlushIfDec | redir));
   assign bus.oEnDecEx    = rst | ~dfz;
   assign bus.oEnExMem    = rst | ~dfz;
   assign bus.oEnMemWb    = rst | ~dfz;
   assign bus.oValidDec   = validDec;
   assign bus.oValidEx    = validEx;
   assign bus.oValidMem   = validMem;
   assign bus.oValidWb    = validWb;
   assign bus.oStallCnt   = stallCnt;
   assign bus.oRedirCnt   = redirCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         pendPc   <= '0;
         validDec <= 1'b0;
         validEx  <= 1'b0;
         validMem <= 1'b0;
         validWb  <= 1'b0;
         stallCnt <= '0;
         redirCnt <= '0;
      end else begin
         state  <= stateNxt;
         pendPc <= pendPcNxt;
         if (~dfz) begin
            validWb  <= validMem;
            validMem <= validEx & ~bus.iFlushExMem;
            validEx  <= validDec & ~bus.iStallDec & ~bus.iFlushDecEx;
            if (bus.iFlushIfDec | redir | (state == PEND))
               validDec <= 1'b0;
            else if (~bus.iStallDec)
               validDec <= ~ifz;
            if (~pcEnable && stallCnt != '1)
               stallCnt <= stallCnt + CNT_W'(1);
            if (redir && redirCnt != '1)
               redirCnt <= redirCnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl, checked every cycle against a behavioural model.
module tb_pipe_ctrl;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chkEn = 1'b0;
   int   nChk = 0;
   int   nFail = 0;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus();
   pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Model: a redirect waiting for fetch, the bubble pattern in each stage, event counts.
   bit          mPend;
   logic [31:0] mPendPc;
   bit          mVd, mVe, mVm, mVw;
   int          mStall, mRedir;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit applyNow();
      return !bus.iDCacheStall && !bus.iICacheStall && (mPend || bus.iRedirectValid);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mPend = 0; mPendPc = '0;
         mVd = 0; mVe = 0; mVm = 0; mVw = 0;
         mStall = 0; mRedir = 0;
      end else if (!bus.iDCacheStall) begin
         bit app, fetch;
         app   = applyNow();
         fetch = !bus.iICacheStall && (!bus.iStallDec || app);
         mVw = mVm;
         mVm = mVe && !bus.iFlushExMem;
         mVe = mVd && !bus.iStallDec && !bus.iFlushDecEx;
         if (bus.iFlushIfDec || app || mPend) mVd = 0;
         else if (!bus.iStallDec)             mVd = !bus.iICacheStall;
         if (!fetch && mStall < CMAX) mStall++;
         if (app && mRedir < CMAX)    mRedir++;
         if (bus.iRedirectValid && bus.iICacheStall) begin
            mPend = 1; mPendPc = bus.iRedirectPC;
         end else if (app) mPend = 0;
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         bit app;
         app = !rst && applyNow();
         chk("pcEnable", bus.oPCEnable,
             !rst && !bus.iDCacheStall && !bus.iICacheStall && (!bus.iStallDec || app));
         chk("pcRedirect", bus.oPCRedirect, app);
         chk("redirectPc", bus.oRedirectPC, mPend ? mPendPc : bus.iRedirectPC);
         chk("enIfDec", bus.oEnIfDec, rst || (!bus.iDCacheStall &&
             (!bus.iStallDec || bus.iFlushIfDec || app)));
         chk("enDecEx", bus.oEnDecEx, rst || !bus.iDCacheStall);
         chk("enExMem", bus.oEnExMem, rst || !bus.iDCacheStall);
         chk("enMemWb", bus.oEnMemWb, rst || !bus.iDCacheStall);
         chk("validDec", bus.oValidDec, mVd);
         chk("validEx", bus.oValidEx, mVe);
         chk("validMem", bus.oValidMem, mVm);
         chk("validWb", bus.oValidWb, mVw);
         chk("stallCnt", bus.oStallCnt, mStall);
         chk("redirCnt", bus.oRedirCnt, mRedir);
      end
   end

   task automatic idle();
      bus.iStallDec = 0; bus.iFlushIfDec = 0; bus.iFlushDecEx = 0; bus.iFlushExMem = 0;
      bus.iICacheStall = 0; bus.iDCacheStall = 0; bus.iRedirectValid = 0; bus.iRedirectPC = '0;
   endtask

   task automatic randIn();
      bus.iStallDec      = ($urandom_range(99) < 20);
      bus.iFlushIfDec    = ($urandom_range(99) < 15);
      bus.iFlushDecEx    = ($urandom_range(99) < 15);
      bus.iFlushExMem    = ($urandom_range(99) < 15);
      bus.iICacheStall   = ($urandom_range(99) < 30);
      bus.iDCacheStall   = ($urandom_range(99) < 15);
      bus.iRedirectValid = ($urandom_range(99) < 20);
      bus.iRedirectPC    = $urandom;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      idle();
      rst = 1;
      tick();
      chkEn = 1;
      // Reset with random inputs
      for (int k = 0; k < 3; k++) begin
         randIn();
         @(negedge clk);
         chk("lit_rstPcEn", bus.oPCEnable, 0);
         chk("lit_rstEnIfDec", bus.oEnIfDec, 1);
         tick();
      end
      rst = 0; idle();
      @(negedge clk);
      chk("lit_rstValid", {bus.oValidDec, bus.oValidEx, bus.oValidMem, bus.oValidWb}, 0);
      chk("lit_rstCnt", bus.oStallCnt, 0);
      chk("lit_firstPcEn", bus.oPCEnable, 1);
      tick();
      @(negedge clk);
      chk("lit_firstValidDec", bus.oValidDec, 1);
      ticks(4);
      // Load-use
      bus.iStallDec = 1;
      @(negedge clk);
      chk("lit_luPcEn", bus.oPCEnable, 0);
      chk("lit_luEnIfDec", bus.oEnIfDec, 0);
      tick(); idle();
      @(negedge clk);
      chk("lit_luValidEx", bus.oValidEx, 0);
      chk("lit_luStallCnt", bus.oStallCnt, 1);
      ticks(3);
      // Taken branch with full flush
      bus.iRedirectValid = 1; bus.iRedirectPC = 32'h0040_0100;
      bus.iFlushIfDec = 1; bus.iFlushDecEx = 1; bus.iFlushExMem = 1;
      @(negedge clk);
      chk("lit_brRedir", bus.oPCRedirect, 1);
      chk("lit_brPc", bus.oRedirectPC, 32'h0040_0100);
      tick(); idle();
      @(negedge clk);
      chk("lit_brValids", {bus.oValidDec, bus.oValidEx, bus.oValidMem}, 0);
      chk("lit_brCnt", bus.oRedirCnt, 1);
      ticks(4);
      // Redirect under I-stall
      bus.iICacheStall = 1; bus.iRedirectValid = 1; bus.iRedirectPC = 32'h100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("lit_isRedirHeld", bus.oPCRedirect, 0);
         tick();
         bus.iRedirectValid = 0; bus.iRedirectPC = 32'h0;
      end
      bus.iICacheStall = 0;
      @(negedge clk);
      chk("lit_isRedir", bus.oPCRedirect, 1);
      chk("lit_isPc", bus.oRedirectPC, 32'h100);
      tick();
      @(negedge clk);
      chk("lit_isDone", bus.oPCRedirect, 0);
      chk("lit_isCnt", bus.oRedirCnt, 2);
      ticks(4);
      // D-freeze with a pending EX/MEM flush
      bus.iDCacheStall = 1; bus.iFlushExMem = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("lit_dfEn", {bus.oEnIfDec, bus.oEnDecEx, bus.oEnExMem, bus.oEnMemWb}, 0);
         chk("lit_dfValids", {bus.oValidDec, bus.oValidEx, bus.oValidMem, bus.oValidWb}, 4'hF);
         tick();
      end
      bus.iDCacheStall = 0;
      @(negedge clk);
      chk("lit_dfStallCnt", bus.oStallCnt, 5);
      tick(); idle();
      @(negedge clk);
      chk("lit_dfMem", bus.oValidMem, 0);
      chk("lit_dfWb", bus.oValidWb, 1);
      tick();
      @(negedge clk);
      chk("lit_dfWb2", bus.oValidWb, 0);
      chk("lit_dfMem2", bus.oValidMem, 1);
      // Saturation
      bus.iStallDec = 1;
      ticks(20);
      @(negedge clk);
      chk("lit_sat", bus.oStallCnt, CMAX);
      idle();
      tick();
      // Randomized traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         randIn();
         rst = ($urandom_range(99) < 3);
         tick();
      end
      rst = 0; idle();
      tick();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
      $finish;
   end
endmodule
